// File: rtl/skin_bbox_tracker_pkg.sv
`default_nettype none
// ============================================================================
// Module      : skin_bbox_tracker_pkg
// Description : Shared constants and types for the skin bounding-box tracker:
//               VGA resolution, coordinate widths, default skin thresholds,
//               the packed 12-bit RGB layout and coordinate averaging helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package skin_bbox_tracker_pkg;

  // Visible resolution of the 25 MHz VGA timing and matching counter widths
  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam int unsigned X_W   = 10;
  localparam int unsigned Y_W   = 9;

  // Qualified-pixel counter and run-length counter widths
  localparam int unsigned CNT_W = 17;
  localparam int unsigned RUN_W = 4;

  // Default skin thresholds and run / count filters
  localparam int unsigned DEF_MIN_RUN   = 4;
  localparam int unsigned DEF_MIN_COUNT = 256;
  localparam int unsigned DEF_R_MIN     = 6;
  localparam int unsigned DEF_RG_DIFF   = 2;

  // Packed pixel layout {R[11:8], G[7:4], B[3:0]}, shared with RGB / RGB2BW
  localparam int unsigned RGB_W = 12;
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Average of two x coordinates, sum taken one bit wider then halved
  function automatic logic [X_W-1:0] avg_x(input logic [X_W-1:0] a,
                                           input logic [X_W-1:0] b);
    logic [X_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[X_W:1];
  endfunction

  // Average of two y coordinates, sum taken one bit wider then halved
  function automatic logic [Y_W-1:0] avg_y(input logic [Y_W-1:0] a,
                                           input logic [Y_W-1:0] b);
    logic [Y_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[Y_W:1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/skin_bbox_tracker_classifier.sv
`default_nettype none
// ============================================================================
// Module      : skin_classifier
// Description : Combinational skin test on a 12-bit RGB pixel:
//               R >= R_MIN, R > G, R > B and (R - G) >= RG_DIFF, with the
//               difference evaluated as a 5-bit signed value.
// Revision    : 1.0 - initial release
// ============================================================================
module skin_classifier
  import skin_bbox_tracker_pkg::*;
#(
  parameter int unsigned R_MIN   = DEF_R_MIN,
  parameter int unsigned RG_DIFF = DEF_RG_DIFF
) (
  input  logic [RGB_W-1:0] rgb,
  output logic             skin
);

  localparam logic [3:0]        R_MIN_V   = 4'(R_MIN);
  localparam logic signed [4:0] RG_DIFF_V = 5'(RG_DIFF);

  rgb444_t           px;
  logic signed [4:0] rg_diff;

  // Unpack the pixel and apply the four skin conditions
  always_comb begin
    px      = rgb;
    rg_diff = $signed({1'b0, px.r}) - $signed({1'b0, px.g});
    skin    = (px.r >= R_MIN_V) && (px.r > px.g) && (px.r > px.b) &&
              (rg_diff >= RG_DIFF_V);
  end

endmodule
`default_nettype wire

// File: rtl/skin_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module      : skin_bbox_tracker
// Description : Classifies the pixel stream as skin / non-skin, run-length
//               filters each line, accumulates a per-frame bounding box of
//               qualified pixels, latches it at the vsync falling edge and
//               drives a registered box-outline overlay flag.
//               Optional macro SKIN_BBOX_SMOOTH_EN: consecutive valid boxes
//               are averaged ((old + new) >> 1) instead of loaded directly.
// Revision    : 1.0 - initial release
// ============================================================================
module skin_bbox_tracker #(
  parameter int unsigned H_RES     = skin_bbox_tracker_pkg::H_RES,
  parameter int unsigned V_RES     = skin_bbox_tracker_pkg::V_RES,
  parameter int unsigned MIN_RUN   = skin_bbox_tracker_pkg::DEF_MIN_RUN,
  parameter int unsigned MIN_COUNT = skin_bbox_tracker_pkg::DEF_MIN_COUNT,
  parameter int unsigned R_MIN     = skin_bbox_tracker_pkg::DEF_R_MIN,
  parameter int unsigned RG_DIFF   = skin_bbox_tracker_pkg::DEF_RG_DIFF
) (
  input  logic        CLK25,
  input  logic        rst,
  input  logic [11:0] rgb,
  input  logic        active,
  input  logic        vsync,
  output logic [9:0]  box_x0,
  output logic [9:0]  box_x1,
  output logic [8:0]  box_y0,
  output logic [8:0]  box_y1,
  output logic        box_valid,
  output logic        frame_done,
  output logic        box_edge
);

  localparam int unsigned X_W   = skin_bbox_tracker_pkg::X_W;
  localparam int unsigned Y_W   = skin_bbox_tracker_pkg::Y_W;
  localparam int unsigned CNT_W = skin_bbox_tracker_pkg::CNT_W;
  localparam int unsigned RUN_W = skin_bbox_tracker_pkg::RUN_W;

  localparam logic [X_W-1:0]   X_MAX     = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0]   Y_MAX     = Y_W'(V_RES - 1);
  localparam logic [X_W-1:0]   RUN_BACK  = X_W'(MIN_RUN - 1);
  localparam logic [RUN_W:0]   RUN_NEED  = (RUN_W + 1)'(MIN_RUN);
  localparam logic [RUN_W-1:0] RUN_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_NEED  = CNT_W'(MIN_COUNT);

  // Pixel position, run filter and edge detectors
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             active_dly_q, active_dly_d;
  logic             vsync_dly_q, vsync_dly_d;

  // Per-frame accumulators
  logic [X_W-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [Y_W-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Latched box and registered outputs
  logic [X_W-1:0]   box_x0_q, box_x0_d, box_x1_q, box_x1_d;
  logic [Y_W-1:0]   box_y0_q, box_y0_d, box_y1_q, box_y1_d;
  logic             box_valid_q, box_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             box_edge_q, box_edge_d;

  // Combinational helpers
  logic             skin;
  logic             frame_end;
  logic             qualify;
  logic [X_W-1:0]   run_start;
  logic             x_on, y_on, x_in, y_in;

  skin_classifier #(
    .R_MIN   (R_MIN),
    .RG_DIFF (RG_DIFF)
  ) u_skin_classifier (
    .rgb  (rgb),
    .skin (skin)
  );

  // Next-state logic for counters, accumulators, box latch and overlay flag
  always_comb begin
    frame_end = vsync_dly_q & ~vsync;
    qualify   = active & skin & (({1'b0, run_q} + 5'd1) >= RUN_NEED);
    run_start = x_q - RUN_BACK;

    active_dly_d = active;
    vsync_dly_d  = vsync;

    // x follows the position inside the active run, clamped at the last column
    if (!active)           x_d = '0;
    else if (x_q == X_MAX) x_d = x_q;
    else                   x_d = x_q + X_W'(1);

    // y advances once per line, on the trailing edge of active
    y_d = y_q;
    if (active_dly_q && !active && (y_q != Y_MAX)) y_d = y_q + Y_W'(1);

    // Skin run length, limited to one line by the active gating
    if (active && skin) run_d = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    else                run_d = '0;

    min_x_d = min_x_q;
    max_x_d = max_x_q;
    min_y_d = min_y_q;
    max_y_d = max_y_q;
    count_d = count_q;

    // Grow the box with each qualified pixel; x0 tracks where the run began
    if (qualify) begin
      if (count_q != CNT_MAX) count_d = count_q + CNT_W'(1);
      if (run_start < min_x_q) min_x_d = run_start;
      if (x_q > max_x_q)       max_x_d = x_q;
      if (y_q < min_y_q)       min_y_d = y_q;
      if (y_q > max_y_q)       max_y_d = y_q;
    end

    box_x0_d     = box_x0_q;
    box_x1_d     = box_x1_q;
    box_y0_d     = box_y0_q;
    box_y1_d     = box_y1_q;
    box_valid_d  = box_valid_q;
    frame_done_d = frame_end;

    // Frame close wins over any same-cycle qualification
    if (frame_end) begin
      if (count_q >= CNT_NEED) begin
        box_valid_d = 1'b1;
`ifdef SKIN_BBOX_SMOOTH_EN
        if (box_valid_q) begin
          box_x0_d = skin_bbox_tracker_pkg::avg_x(box_x0_q, min_x_q);
          box_x1_d = skin_bbox_tracker_pkg::avg_x(box_x1_q, max_x_q);
          box_y0_d = skin_bbox_tracker_pkg::avg_y(box_y0_q, min_y_q);
          box_y1_d = skin_bbox_tracker_pkg::avg_y(box_y1_q, max_y_q);
        end else begin
          box_x0_d = min_x_q;
          box_x1_d = max_x_q;
          box_y0_d = min_y_q;
          box_y1_d = max_y_q;
        end
`else
        box_x0_d = min_x_q;
        box_x1_d = max_x_q;
        box_y0_d = min_y_q;
        box_y1_d = max_y_q;
`endif
      end else begin
        box_valid_d = 1'b0;
      end
      min_x_d = X_MAX;
      max_x_d = '0;
      min_y_d = Y_MAX;
      max_y_d = '0;
      count_d = '0;
      y_d     = '0;
      run_d   = '0;
    end

    // Outline test against the box currently on display
    x_on       = (x_q == box_x0_q) || (x_q == box_x1_q);
    y_on       = (y_q == box_y0_q) || (y_q == box_y1_q);
    x_in       = (x_q >= box_x0_q) && (x_q <= box_x1_q);
    y_in       = (y_q >= box_y0_q) && (y_q <= box_y1_q);
    box_edge_d = box_valid_q & active & ((x_on & y_in) | (y_on & x_in));
  end

  // State registers with synchronous reset
  always_ff @(posedge CLK25) begin
    if (rst) begin
      x_q          <= '0;
      y_q          <= '0;
      run_q        <= '0;
      active_dly_q <= 1'b0;
      vsync_dly_q  <= 1'b1;
      min_x_q      <= X_MAX;
      max_x_q      <= '0;
      min_y_q      <= Y_MAX;
      max_y_q      <= '0;
      count_q      <= '0;
      box_x0_q     <= '0;
      box_x1_q     <= '0;
      box_y0_q     <= '0;
      box_y1_q     <= '0;
      box_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      box_edge_q   <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      run_q        <= run_d;
      active_dly_q <= active_dly_d;
      vsync_dly_q  <= vsync_dly_d;
      min_x_q      <= min_x_d;
      max_x_q      <= max_x_d;
      min_y_q      <= min_y_d;
      max_y_q      <= max_y_d;
      count_q      <= count_d;
      box_x0_q     <= box_x0_d;
      box_x1_q     <= box_x1_d;
      box_y0_q     <= box_y0_d;
      box_y1_q     <= box_y1_d;
      box_valid_q  <= box_valid_d;
      frame_done_q <= frame_done_d;
      box_edge_q   <= box_edge_d;
    end
  end

  assign box_x0     = box_x0_q;
  assign box_x1     = box_x1_q;
  assign box_y0     = box_y0_q;
  assign box_y1     = box_y1_q;
  assign box_valid  = box_valid_q;
  assign frame_done = frame_done_q;
  assign box_edge   = box_edge_q;

endmodule
`default_nettype wire

// File: tb/tb_skin_bbox_tracker.sv
`default_nettype none
// ============================================================================
// Module      : tb_skin_bbox_tracker
// Description : Self-checking bench for skin_bbox_tracker. Frames are built
//               from directed and random pixel patterns; a frame-level model
//               (sliding skin window per line, box extents per frame) gives
//               the expected frame_done, box_edge and latched box values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skin_bbox_tracker;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int MIN_RUN   = 4;
  localparam int MIN_COUNT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] rgb;
  logic        active;
  logic        vsync;
  logic [9:0]  box_x0, box_x1;
  logic [8:0]  box_y0, box_y1;
  logic        box_valid, frame_done, box_edge;

  always #20 clk = ~clk;

  skin_bbox_tracker dut (
    .CLK25      (clk),
    .rst        (rst),
    .rgb        (rgb),
    .active     (active),
    .vsync      (vsync),
    .box_x0     (box_x0),
    .box_x1     (box_x1),
    .box_y0     (box_y0),
    .box_y1     (box_y1),
    .box_valid  (box_valid),
    .frame_done (frame_done),
    .box_edge   (box_edge)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: displayed box, frame extents, line history
  int m_x0, m_x1, m_y0, m_y1;
  bit m_valid;
  int a_minx, a_maxx, a_miny, a_maxy, a_count;
  int line_idx;
  bit prev_active, prev_vs;
  bit hist[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_skin(input logic [11:0] p);
    int r, g, b;
    r = int'(p[11:8]);
    g = int'(p[7:4]);
    b = int'(p[3:0]);
    return (r >= 6) && (r > g) && (r > b) && ((r - g) >= 2);
  endfunction

  function automatic void clear_frame_acc();
    a_minx  = H_RES - 1;
    a_maxx  = 0;
    a_miny  = V_RES - 1;
    a_maxy  = 0;
    a_count = 0;
  endfunction

  // One pixel clock: drive inputs, step the model, compare outputs
  task automatic tick(input logic [11:0] p, input bit a, input bit vs);
    int  xm, ym;
    bit  fe, sk, qual, exp_edge;
    xm = (hist.size() > H_RES - 1) ? H_RES - 1 : hist.size();
    ym = (line_idx > V_RES - 1) ? V_RES - 1 : line_idx;
    exp_edge = m_valid && a &&
               ((((xm == m_x0) || (xm == m_x1)) && (ym >= m_y0) && (ym <= m_y1)) ||
                (((ym == m_y0) || (ym == m_y1)) && (xm >= m_x0) && (xm <= m_x1)));
    fe = prev_vs && !vs;
    sk = a && is_skin(p);
    if (a) hist.push_back(sk);
    qual = 0;
    if (a && !fe && (hist.size() >= MIN_RUN)) begin
      qual = 1;
      for (int k = 0; k < MIN_RUN; k++)
        if (!hist[hist.size() - 1 - k]) qual = 0;
    end

    rgb = p; active = a; vsync = vs;
    @(posedge clk);
    #1;
    check("frame_done", frame_done, fe);
    check("box_edge", box_edge, exp_edge);

    if (qual) begin
      a_count++;
      if (xm - (MIN_RUN - 1) < a_minx) a_minx = xm - (MIN_RUN - 1);
      if (xm > a_maxx) a_maxx = xm;
      if (ym < a_miny) a_miny = ym;
      if (ym > a_maxy) a_maxy = ym;
    end
    if (fe) begin
      if (a_count >= MIN_COUNT) begin
`ifdef SKIN_BBOX_SMOOTH_EN
        if (m_valid) begin
          m_x0 = (m_x0 + a_minx) / 2; m_x1 = (m_x1 + a_maxx) / 2;
          m_y0 = (m_y0 + a_miny) / 2; m_y1 = (m_y1 + a_maxy) / 2;
        end else begin
          m_x0 = a_minx; m_x1 = a_maxx; m_y0 = a_miny; m_y1 = a_maxy;
        end
`else
        m_x0 = a_minx; m_x1 = a_maxx; m_y0 = a_miny; m_y1 = a_maxy;
`endif
        m_valid = 1;
      end else begin
        m_valid = 0;
      end
      check("box_valid", box_valid, m_valid);
      check("box_x0", box_x0, m_x0);
      check("box_x1", box_x1, m_x1);
      check("box_y0", box_y0, m_y0);
      check("box_y1", box_y1, m_y1);
      clear_frame_acc();
      line_idx = 0;
      hist.delete();
    end else if (prev_active && !a) begin
      line_idx++;
    end
    prev_active = a;
    prev_vs     = vs;
    if (!a) hist.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1; rgb = '0; active = 1'b0; vsync = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_box_x0", box_x0, 0);
    check("rst_box_x1", box_x1, 0);
    check("rst_box_y0", box_y0, 0);
    check("rst_box_y1", box_y1, 0);
    check("rst_box_valid", box_valid, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_box_edge", box_edge, 0);
    m_x0 = 0; m_x1 = 0; m_y0 = 0; m_y1 = 0; m_valid = 0;
    clear_frame_acc();
    line_idx = 0;
    prev_active = 0;
    prev_vs = 1;
    hist.delete();
  endtask

  // kind: 0 black, 1 rect, 2 noise, 3 runs of 3, 4 single run of 4, 5 rect+noise, 6 all skin
  function automatic logic [11:0] pix(input int kind, input int x, input int y,
                                      input int rx0, input int rx1, input int ry0, input int ry1);
    bit in_rect;
    in_rect = (x >= rx0) && (x <= rx1) && (y >= ry0) && (y <= ry1);
    case (kind)
      1: return in_rect ? 12'hA53 : 12'h000;
      2: return 12'($urandom);
      3: return (((x % 8) < 3) && (y % 3 == 1)) ? 12'hC42 : 12'h123;
      4: return ((y == 5) && (x >= 10) && (x <= 13)) ? 12'hA53 : 12'h000;
      5: return in_rect ? 12'hA53 : 12'($urandom);
      6: return 12'hF80;
      default: return 12'h000;
    endcase
  endfunction

  // One frame: vblank, nl lines of w pixels, then a vsync pulse.
  // rst_after >= 0 pulses reset in the blanking after that line;
  // coinc makes vsync fall on the final active pixel.
  task automatic frame(input int nl, input int w, input int kind,
                       input int rx0, input int rx1, input int ry0, input int ry1,
                       input int rst_after, input bit coinc);
    repeat (3) tick(12'h000, 0, 1);
    for (int l = 0; l < nl; l++) begin
      for (int i = 0; i < w; i++) begin
        bit last;
        last = coinc && (l == nl - 1) && (i == w - 1);
        tick(pix(kind, i, l, rx0, rx1, ry0, ry1), 1, !last);
      end
      if (!(coinc && (l == nl - 1))) begin
        tick(12'h000, 0, 1);
        tick(12'h000, 0, 1);
        if (l == rst_after) apply_reset();
      end
    end
    if (coinc) begin
      tick(12'h000, 0, 0);
      tick(12'h000, 0, 1);
    end else begin
      tick(12'h000, 0, 0);
      tick(12'h000, 0, 0);
      tick(12'h000, 0, 1);
    end
  endtask

  initial begin
    rst = 1'b1; rgb = '0; active = 1'b0; vsync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    apply_reset();

    // Two black frames: no box, no overlay
    frame(6, 20, 0, 0, 0, 0, 0, -1, 0);
    frame(6, 20, 0, 0, 0, 0, 0, -1, 0);
    check("black_valid", box_valid, 0);

    // Skin square x 10..39, y 5..20: 27 qualified per row x 16 rows
    frame(24, 48, 1, 10, 39, 5, 20, -1, 0);
    check("sq_valid", box_valid, 1);
    check("sq_x0", box_x0, 10);
    check("sq_x1", box_x1, 39);
    check("sq_y0", box_y0, 5);
    check("sq_y1", box_y1, 20);

    // Same square again: outline overlay checked pixel by pixel
    frame(24, 48, 1, 10, 39, 5, 20, -1, 0);

    // Runs of three never qualify; a single run of four is below MIN_COUNT
    frame(12, 40, 3, 0, 0, 0, 0, -1, 0);
    check("run3_valid", box_valid, 0);
    frame(8, 20, 4, 0, 0, 0, 0, -1, 0);
    check("run4_valid", box_valid, 0);

    // Valid square then an undersized frame: valid drops, box holds
    frame(24, 48, 1, 10, 39, 5, 20, -1, 0);
    frame(24, 48, 1, 20, 39, 5, 14, -1, 0);
    check("small_valid", box_valid, 0);
    check("small_x0", box_x0, 10);
    check("small_y1", box_y1, 20);

    // Reset mid-frame after the skin rows; remaining partial frame is empty
    frame(30, 48, 1, 10, 39, 5, 20, 22, 0);
    check("postrst_valid", box_valid, 0);

    // Vsync falling on a skin pixel: that pixel is dropped
    frame(20, 40, 6, 0, 39, 0, 19, -1, 1);

    // Wide line saturating x, tall frame saturating y
    frame(1, 700, 6, 0, 0, 0, 0, -1, 0);
    check("wide_x1", box_x1, H_RES - 1);
    frame(482, 4, 6, 0, 0, 0, 0, -1, 0);
    check("tall_y1", box_y1, V_RES - 1);

    // Randomised frames
    for (int f = 0; f < 15; f++) begin
      int nl, w, kind, rx0, rx1, ry0, ry1;
      nl   = $urandom_range(4, 30);
      w    = $urandom_range(4, 50);
      case ($urandom_range(0, 3))
        0: kind = 0;
        1: kind = 1;
        2: kind = 2;
        default: kind = 5;
      endcase
      rx0 = $urandom_range(0, w - 1);
      rx1 = $urandom_range(rx0, w - 1);
      ry0 = $urandom_range(0, nl - 1);
      ry1 = $urandom_range(ry0, nl - 1);
      frame(nl, w, kind, rx0, rx1, ry0, ry1, -1, ($urandom_range(0, 4) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
